md5_stream_core: RTL and testbench

Parametrised successor to the single-block MD5 datapath. It computes standard RFC 1321 MD5 over pre-padded messages of one or more 512-bit blocks. Blocks arrive as a beat stream with a valid/ready handshake, and chaining state carries across blocks. The core sits between the message padder and the digest collector in the hash subsystem, and retires UNROLL rounds per clock.

---
 rtl/md5_stream_core.sv | 171 +++++++++++++++++
 tb/tb_md5_stream_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_stream_core.sv
// MD5 chaining core: IN_W-bit beats of pre-padded 512-bit blocks in, UNROLL rounds per clock, 128-bit digest out.
// Digest valid 64/UNROLL+2 cycles after the last beat; in_ready drops from block end until the digest is taken.
module md5_stream_core #(
  parameter int IN_W   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_first,
  input  logic            in_last,
  output logic            digest_valid,
  input  logic            digest_ready,
  output logic [127:0]    digest,
  output logic            busy
);
  localparam int BPB = 512 / IN_W;
  localparam int BW  = (BPB > 1) ? $clog2(BPB) : 1;
  localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  // Shift amount depends only on the round group and the step position within each group of four.
  localparam logic [4:0] S [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FINAL, OUT} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [5:0]    rnd_q, rnd_d;
  logic [511:0]  blk_q, blk_d;
  logic [127:0]  h_q, h_d, st_q, st_d, dig_q, dig_d;
  logic          first_q, first_d, last_q, last_d, ld_q, ld_d;
  logic [31:0]   mw [16];
  logic [127:0]  st_rnd;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Block is held as a byte stream (byte 0 at the top); message words are little-endian.
  always_comb begin
    for (int j = 0; j < 16; j++) mw[j] = bswap(blk_q[511-32*j -: 32]);
  end

  always_comb begin
    logic [31:0] a, b, c, d, f, t;
    logic [5:0]  i;
    logic [3:0]  g;
    logic [63:0] rot;
    {a, b, c, d} = st_q;
    for (int u = 0; u < UNROLL; u++) begin
      i = rnd_q + 6'(u);
      case (i[5:4])
        2'd0:    begin f = (b & c) | (~b & d); g = i[3:0]; end
        2'd1:    begin f = (d & b) | (~d & c); g = i[3:0] * 4'd5 + 4'd1; end
        2'd2:    begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5; end
        default: begin f = c ^ (b | ~d);       g = i[3:0] * 4'd7; end
      endcase
      t   = a + f + K[i] + mw[g];
      rot = {t, t} << S[{i[5:4], i[1:0]}];
      a   = d;
      d   = c;
      c   = b;
      b   = b + rot[63:32];
    end
    st_rnd = {a, b, c, d};
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    h_d     = h_q;
    st_d    = st_q;
    dig_d   = dig_q;
    first_d = first_q;
    last_d  = last_q;
    ld_d    = ld_q;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < BPB; k++)
            if (beat_q == BW'(k)) blk_d[511-k*IN_W -: IN_W] = in_data;
          if (beat_q == '0) first_d = in_first;
          if (beat_q == BW'(BPB - 1)) begin
            last_d  = in_last;
            beat_d  = '0;
            ld_d    = 1'b1;
            state_d = COMPUTE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      COMPUTE: begin
        // First compute cycle only seeds the working registers.
        if (ld_q) begin
          st_d = first_q ? IV : h_q;
          if (first_q) h_d = IV;
          ld_d = 1'b0;
        end else begin
          st_d  = st_rnd;
          rnd_d = rnd_q + 6'(UNROLL);
          if (rnd_q == 6'(64 - UNROLL)) state_d = FINAL;
        end
      end
      FINAL: begin
        h_d[127:96] = h_q[127:96] + st_q[127:96];
        h_d[95:64]  = h_q[95:64]  + st_q[95:64];
        h_d[63:32]  = h_q[63:32]  + st_q[63:32];
        h_d[31:0]   = h_q[31:0]   + st_q[31:0];
        if (last_q) begin
          dig_d   = {bswap(h_d[127:96]), bswap(h_d[95:64]), bswap(h_d[63:32]), bswap(h_d[31:0])};
          state_d = OUT;
        end else begin
          state_d = LOAD;
        end
      end
      OUT: if (digest_ready) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rnd_q   <= '0;
      blk_q   <= '0;
      h_q     <= IV;
      st_q    <= '0;
      dig_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      h_q     <= h_d;
      st_q    <= st_d;
      dig_q   <= dig_d;
      first_q <= first_d;
      last_q  <= last_d;
      ld_q    <= ld_d;
    end
  end

  assign in_ready     = (state_q == LOAD);
  assign digest_valid = (state_q == OUT);
  assign busy         = (state_q != IDLE);
  assign digest       = dig_q;

endmodule

// File: tb/tb_md5_stream_core.sv
// Directed checks of md5_stream_core across three beat-width / unroll configurations.
module tb_md5_stream_core;
  localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] DIG_TWO   = 128'h57edf4a22be3c955ac49da2e2107b67a;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   in_valid = '0;
  logic [2:0]   in_ready;
  logic [511:0] in_data [3] = '{default: '0};
  logic [2:0]   in_first = '0;
  logic [2:0]   in_last = '0;
  logic [2:0]   digest_valid;
  logic [2:0]   digest_ready = '1;
  logic [127:0] digest [3];
  logic [2:0]   busy;

  int errors = 0;
  int checks = 0;
  int beat_cnt [3] = '{0, 0, 0};
  int xfer_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  md5_stream_core #(.IN_W(32), .UNROLL(1)) u_w32 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][31:0]), .in_first(in_first[0]), .in_last(in_last[0]),
    .digest_valid(digest_valid[0]), .digest_ready(digest_ready[0]), .digest(digest[0]), .busy(busy[0]));
  md5_stream_core #(.IN_W(128), .UNROLL(4)) u_w128 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][127:0]), .in_first(in_first[1]), .in_last(in_last[1]),
    .digest_valid(digest_valid[1]), .digest_ready(digest_ready[1]), .digest(digest[1]), .busy(busy[1]));
  md5_stream_core #(.IN_W(64), .UNROLL(8)) u_w64 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][63:0]), .in_first(in_first[2]), .in_last(in_last[2]),
    .digest_valid(digest_valid[2]), .digest_ready(digest_ready[2]), .digest(digest[2]), .busy(busy[2]));

  // Handshake scoreboard: beats consumed and digests transferred per instance.
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (in_valid[n] && in_ready[n]) beat_cnt[n] <= beat_cnt[n] + 1;
      if (digest_valid[n] && digest_ready[n]) xfer_cnt[n] <= xfer_cnt[n] + 1;
    end
  end

  function automatic int w_of(input int n);
    return (n == 0) ? 32 : (n == 1) ? 128 : 64;
  endfunction

  function automatic logic [511:0] abc_blk();
    logic [511:0] b;
    b = '0;
    b[511 -: 32] = 32'h61626380;
    b[511-8*56 -: 8] = 8'h18;
    return b;
  endfunction

  function automatic logic [511:0] digits_blk(input int base, input int count);
    logic [511:0] b;
    int v;
    b = '0;
    for (int i = 0; i < count; i++) begin
      v = (base + i) % 10;
      b[511-8*i -: 8] = (v == 9) ? 8'h30 : 8'(8'h31 + v);
    end
    return b;
  endfunction

  // Beat 0 carries 'first' and the final beat carries 'last'; other beats carry the opposite
  // values, which the core must ignore. Returns at the negedge after the last beat's edge.
  task automatic send_block(input int n, input logic [511:0] blk, input logic first, input logic last,
                            input bit gaps, output bit ok);
    int k, w, cyc;
    w = w_of(n);
    k = 0;
    cyc = 0;
    while (k < 512 / w && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid[n] = 1'b0;
      end else begin
        in_data[n]  = blk >> (512 - (k + 1) * w);
        in_first[n] = (k == 0) ? first : ~first;
        in_last[n]  = (k == 512 / w - 1) ? last : ~last;
        in_valid[n] = 1'b1;
        if (in_ready[n]) k++;
      end
    end
    @(negedge clk);
    in_valid[n] = 1'b0;
    ok = (k == 512 / w);
  endtask

  task automatic wait_digest(input int n, output int lat);
    lat = 0;
    while (!digest_valid[n] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if ({busy[n], in_ready[n], digest_valid[n]} !== 3'b000 || digest[n] !== '0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: busy/rdy/dv=%b digest=%h, required 000 and 0", n,
                 {busy[n], in_ready[n], digest_valid[n]}, digest[n]);
      end
    end
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      checks++;
      if ({busy[n], in_ready[n], digest_valid[n]} !== 3'b110) begin
        errors++;
        $display("FAIL reset_load[%0d]: busy/rdy/dv=%b, required 110", n, {busy[n], in_ready[n], digest_valid[n]});
      end
    end
  endtask

  task automatic test_empty_msg();
    bit ok;
    int lat;
    send_block(0, {8'h80, 504'h0}, 1'b1, 1'b1, 1'b0, ok);
    wait_digest(0, lat);
    checks++;
    if (!ok || lat != 66) begin
      errors++;
      $display("FAIL empty_latency: sent=%0d latency=%0d, required 1 and 66", ok, lat);
    end
    checks++;
    if (digest[0] !== DIG_EMPTY) begin
      errors++;
      $display("FAIL empty_digest: got %h required %h", digest[0], DIG_EMPTY);
    end
    @(negedge clk);
    checks++;
    if (digest_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL empty_release: dv=%b rdy=%b, required 0 1", digest_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_abc_w128();
    bit ok;
    int lat, b0;
    b0 = beat_cnt[1];
    send_block(1, abc_blk(), 1'b1, 1'b1, 1'b0, ok);
    wait_digest(1, lat);
    checks++;
    if (!ok || lat != 18) begin
      errors++;
      $display("FAIL abc128_latency: sent=%0d latency=%0d, required 1 and 18", ok, lat);
    end
    checks++;
    if (digest[1] !== DIG_ABC) begin
      errors++;
      $display("FAIL abc128_digest: got %h required %h", digest[1], DIG_ABC);
    end
    checks++;
    if (beat_cnt[1] - b0 != 4) begin
      errors++;
      $display("FAIL abc128_beats: got %0d required 4", beat_cnt[1] - b0);
    end
  endtask

  task automatic test_two_block();
    bit ok1, ok2, dv_seen;
    int gap, lat;
    logic [511:0] b2;
    b2 = digits_blk(64, 16);
    b2[511-8*16 -: 8] = 8'h80;
    b2[511-8*56 -: 16] = 16'h8002;
    send_block(0, digits_blk(0, 64), 1'b1, 1'b0, 1'b0, ok1);
    gap = 0;
    dv_seen = 1'b0;
    while (!in_ready[0] && gap < 200) begin
      @(negedge clk);
      gap++;
      if (digest_valid[0]) dv_seen = 1'b1;
    end
    checks++;
    if (dv_seen || gap != 66) begin
      errors++;
      $display("FAIL two_block_mid: dv_seen=%0d gap=%0d, required 0 and 66", dv_seen, gap);
    end
    send_block(0, b2, 1'b0, 1'b1, 1'b0, ok2);
    wait_digest(0, lat);
    checks++;
    if (!ok1 || !ok2 || digest[0] !== DIG_TWO) begin
      errors++;
      $display("FAIL two_block_digest: got %h required %h (sent %0d %0d)", digest[0], DIG_TWO, ok1, ok2);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat, x0;
    digest_ready[1] = 1'b0;
    x0 = xfer_cnt[1];
    send_block(1, abc_blk(), 1'b1, 1'b1, 1'b0, ok);
    wait_digest(1, lat);
    checks++;
    if (!ok || lat != 18) begin
      errors++;
      $display("FAIL bp_latency: sent=%0d latency=%0d, required 1 and 18", ok, lat);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (digest_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 || digest[1] !== DIG_ABC) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: dv=%b rdy=%b digest=%h, required 1 0 %h", c,
                 digest_valid[1], in_ready[1], digest[1], DIG_ABC);
      end
    end
    digest_ready[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (digest_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || xfer_cnt[1] - x0 != 1) begin
      errors++;
      $display("FAIL bp_release: dv=%b rdy=%b transfers=%0d, required 0 1 1", digest_valid[1], in_ready[1],
               xfer_cnt[1] - x0);
    end
    send_block(1, abc_blk(), 1'b1, 1'b1, 1'b0, ok);
    wait_digest(1, lat);
    checks++;
    if (!ok || digest[1] !== DIG_ABC) begin
      errors++;
      $display("FAIL bp_rehash: got %h required %h (sent %0d)", digest[1], DIG_ABC, ok);
    end
  endtask

  task automatic test_reset_mid_compute();
    bit ok;
    int lat;
    send_block(0, {8'h80, 504'h0}, 1'b1, 1'b1, 1'b0, ok);
    repeat (21) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0 || digest_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL midc_before: busy=%b rdy=%b dv=%b, required 1 0 0", busy[0], in_ready[0], digest_valid[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || in_ready[0] !== 1'b0 || digest[0] !== '0) begin
      errors++;
      $display("FAIL midc_idle: busy=%b rdy=%b digest=%h, required 0 0 0", busy[0], in_ready[0], digest[0]);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b1 || digest_valid[0] !== 1'b0 || digest[0] !== '0) begin
      errors++;
      $display("FAIL midc_load: busy=%b rdy=%b dv=%b digest=%h, required 1 1 0 0", busy[0], in_ready[0],
               digest_valid[0], digest[0]);
    end
    send_block(0, {8'h80, 504'h0}, 1'b1, 1'b1, 1'b0, ok);
    wait_digest(0, lat);
    checks++;
    if (!ok || lat != 66 || digest[0] !== DIG_EMPTY) begin
      errors++;
      $display("FAIL midc_rerun: latency=%0d digest=%h, required 66 %h", lat, digest[0], DIG_EMPTY);
    end
  endtask

  task automatic test_gaps_w64();
    bit ok;
    int lat, b0;
    b0 = beat_cnt[2];
    send_block(2, abc_blk(), 1'b1, 1'b1, 1'b1, ok);
    wait_digest(2, lat);
    checks++;
    if (!ok || lat != 10) begin
      errors++;
      $display("FAIL gaps_latency: sent=%0d latency=%0d, required 1 and 10", ok, lat);
    end
    checks++;
    if (digest[2] !== DIG_ABC) begin
      errors++;
      $display("FAIL gaps_digest: got %h required %h", digest[2], DIG_ABC);
    end
    checks++;
    if (beat_cnt[2] - b0 != 8) begin
      errors++;
      $display("FAIL gaps_beats: got %0d required 8", beat_cnt[2] - b0);
    end
  endtask

  initial begin
    test_reset();
    test_empty_msg();
    test_abc_w128();
    test_two_block();
    test_backpressure();
    test_reset_mid_compute();
    test_gaps_w64();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
